conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator that sits directly upstream of the 3x3 `conv` stage. It accepts one raster-order pixel per cycle and buffers the previous SIZE-1 image rows in line buffers. For every valid (unpadded) SIZE x SIZE neighbourhood it presents a registered window in the same `[row][col]` layout that `conv` consumes on `inpMatrixI`.

## Interface
- `SIZE`, 3, window edge length; must be ≥2.
- `WIDTH_BIT`, 8, pixel width.
- `IMG_W`, 28, image width in pixels; must be ≥ SIZE.
- `IMG_H`, 28, image height in pixels; must be ≥ SIZE.
- `clock`  in  1  single clock; all logic on its rising edge.
- `nreset`  in  1  reset, synchronous and active-low.
- `pix_valid`  in  1  pixel accepted on every rising edge where it is 1; no backpressure.
- `pix_data`  in  WIDTH_BIT  pixel value.
- `win_valid`  out  1  window outputs valid this cycle.
- `win`  out  WIDTH_BIT × [SIZE-1:0][SIZE-1:0]  window; `[0][0]` = top-left (oldest), `[SIZE-1][SIZE-1]` = newest pixel.
- `win_x`  out  $clog2(IMG_W)  column of the window's top-left pixel.
- `win_y`  out  $clog2(IMG_H)  row of the window's top-left pixel.
- `frame_done`  out  1  one-cycle pulse coinciding with the last window of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next pixel to be accepted.
- Line buffers `lb[0..SIZE-2]`, each IMG_W deep, addressed by `col`. `lb[0]` holds the previous row; `lb[k]` holds the row k+1 above.
- On an accepted pixel:
  - Build the new column: `newcol[SIZE-1] = pix_data`, and `newcol[SIZE-2-k] = lb[k][col]` for each k (reads happen before the write).
  - Write `lb[0][col] <= pix_data` and `lb[k][col] <= lb[k-1][col]`.
  - Shift the window left one column: `win[r][c] <= win[r][c+1]`, and `win[r][SIZE-1] <= newcol[r]`.
- Window valid condition: `row ≥ SIZE-1 && col ≥ SIZE-1` at accept time. When it holds, `win_valid <= 1`, `win_x <= col-(SIZE-1)`, `win_y <= row-(SIZE-1)`.
- FSM, qualified by the accepted pixel:
  - ST_FILL: while `row < SIZE-1`; leaves to ST_RUN when the pixel at `col = IMG_W-1, row = SIZE-2` is accepted.
  - ST_RUN: returns to ST_FILL after the pixel at `col = IMG_W-1, row = IMG_H-1` is accepted.
- Counter wrap: at `col = IMG_W-1`, `col <= 0` and `row++`. At the last pixel of a frame, `row <= 0` and `frame_done <= 1` together with the final `win_valid`.
- Row boundary: the window shift register carries stale columns from the previous row. These are masked because no window is valid while `col < SIZE-1`.
- Back-to-back frames need no idle cycle. Stale line-buffer contents are never exposed, because the first SIZE-1 rows of each frame are fill rows.
- Arithmetic: pure data movement, no width change; `pix_data` is passed through unaltered.

## Timing
- Latency: the window whose newest pixel is accepted at edge t is visible after edge t, and `win_valid` is high for exactly that one cycle.
- `win_valid` and `frame_done` fall to 0 on any cycle with no accepted pixel. `win`, `win_x` and `win_y` hold their last value.
- `pix_valid = 0` cycles stall all state; the output window sequence is independent of gaps.
- Throughput: one window per cycle in ST_RUN for valid columns. A frame yields (IMG_W-SIZE+1)·(IMG_H-SIZE+1) windows.
- Reset (`nreset = 0` at an edge) sets:
  - `col = row = 0`, state ST_FILL;
  - `win_valid = frame_done = 0`, `win = 0`, `win_x = win_y = 0`.
- Line buffers are not cleared. Reset mid-frame discards the partial frame, and the next accepted pixel is treated as (0,0).
- Reset has priority over a simultaneous `pix_valid`.

## Structure
- Shared package `cnn_pkg`:
  - `win_state_t` enum {ST_FILL, ST_RUN};
  - default `SIZE`, `WIDTH_BIT`, `IMG_W`, `IMG_H` localparams, shared with `conv`.
- Sub-module `line_buffer`:
  - IMG_W × WIDTH_BIT, one address, read-before-write in the same cycle, write enable;
  - instantiated SIZE-1 times in a generate loop.
- Top level holds the counters, FSM, window shift register and output registers.

## Test plan
- Basic frame (SIZE=3, IMG_W=IMG_H=5, pixels 0..24, continuous valid):
  - first `win_valid` the cycle after pixel 12, with `win` = {{0,1,2},{5,6,7},{10,11,12}}, `win_x = 0`, `win_y = 0`;
  - exactly 9 windows in total;
  - last window {{12,13,14},{17,18,19},{22,23,24}} at (2,2), with `frame_done = 1` in the same cycle.
- Row wrap: in the basic frame, no `win_valid` after pixels 15, 16, 20 or 21. The window after pixel 17 is {{5,6,7},{10,11,12},{15,16,17}}.
- Random `pix_valid` gaps (about 40% idle) on the same frame: an identical 9-window sequence. `win_valid` is never high on a cycle following an idle input cycle.
- Back-to-back frames: frame 2 = 100..124 immediately after frame 1. Its first window is {{100,101,102},{105,106,107},{110,111,112}}, with no frame-1 values leaking.
- Reset mid-frame: after 14 pixels, hold `nreset = 0` for one cycle.
  - All outputs read 0 on the following cycle.
  - Then send 200..224: first window {{200,201,202},{205,206,207},{210,211,212}} after the 13th pixel.
- Reset coincident with `pix_valid = 1`: that pixel is dropped and the counters read 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: default geometry and the window-generator state type.
package cnn_pkg;

    localparam int SIZE      = 3;
    localparam int WIDTH_BIT = 8;
    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; asynchronous read of the addressed entry, so the
// old contents are seen in the same cycle they are overwritten.
module line_buffer #(
    parameter int DEPTH     = 28,
    parameter int WIDTH_BIT = 8
) (
    input  logic                         clock,
    input  logic                         we_i,
    input  logic [$clog2(DEPTH)-1:0]     addr_i,
    input  logic [WIDTH_BIT-1:0]         wr_data_i,
    output logic [WIDTH_BIT-1:0]         rd_data_o
);

    logic [WIDTH_BIT-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[addr_i];

    // No reset: contents are only ever read after a full fill row has overwritten them.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to SIZE x SIZE sliding window, feeding the conv stage.
// State | meaning: ST_FILL = first SIZE-1 rows of a frame, no windows; ST_RUN = windows emitted.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int SIZE      = cnn_pkg::SIZE,
    parameter int WIDTH_BIT = cnn_pkg::WIDTH_BIT,
    parameter int IMG_W     = cnn_pkg::IMG_W,
    parameter int IMG_H     = cnn_pkg::IMG_H
) (
    input  logic                                       clock,
    input  logic                                       nreset,
    input  logic                                       pix_valid,
    input  logic [WIDTH_BIT-1:0]                       pix_data,
    output logic                                       win_valid,
    output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]   win,
    output logic [$clog2(IMG_W)-1:0]                   win_x,
    output logic [$clog2(IMG_H)-1:0]                   win_y,
    output logic                                       frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] COL_LAST      = XW'(IMG_W - 1);
    localparam logic [XW-1:0] COL_FIRST     = XW'(SIZE - 1);
    localparam logic [YW-1:0] ROW_LAST      = YW'(IMG_H - 1);
    localparam logic [YW-1:0] ROW_FIRST     = YW'(SIZE - 1);
    localparam logic [YW-1:0] ROW_FILL_LAST = YW'(SIZE - 2);

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    win_state_t    state_q;
    logic          col_last, row_last;

    logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_q, win_d;
    logic [SIZE-1:0][WIDTH_BIT-1:0]           newcol;
    logic                                     win_valid_q;
    logic                                     frame_done_q;
    logic [XW-1:0]                            win_x_q;
    logic [YW-1:0]                            win_y_q;

    logic [WIDTH_BIT-1:0] lb_rd [SIZE-1];
    logic [WIDTH_BIT-1:0] lb_wr [SIZE-1];
    logic                 lb_we;

    // A pixel coinciding with reset is dropped, including its line-buffer write.
    assign lb_we = pix_valid && nreset;

    for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
        line_buffer #(
            .DEPTH     (IMG_W),
            .WIDTH_BIT (WIDTH_BIT)
        ) u_lb (
            .clock     (clock),
            .we_i      (lb_we),
            .addr_i    (col_q),
            .wr_data_i (lb_wr[k]),
            .rd_data_o (lb_rd[k])
        );
    end

    always_comb begin
        lb_wr[0] = pix_data;
        for (int k = 1; k < SIZE - 1; k++) begin
            lb_wr[k] = lb_rd[k-1];
        end
    end

    always_comb begin
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
        col_d    = col_last ? '0 : col_q + XW'(1);
        row_d    = row_q;
        if (col_last) begin
            row_d = row_last ? '0 : row_q + YW'(1);
        end
    end

    // Newest pixel lands in the bottom row; older rows come out of the line buffers.
    always_comb begin
        newcol         = '0;
        newcol[SIZE-1] = pix_data;
        for (int k = 0; k < SIZE - 1; k++) begin
            newcol[SIZE-2-k] = lb_rd[k];
        end
    end

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][SIZE-1] = newcol[r];
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= ST_FILL;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (pix_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
                case (state_q)
                    ST_FILL: begin
                        if (col_last && row_q == ROW_FILL_LAST) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Columns left of SIZE-1 still hold the previous row's tail.
                        if (col_q >= COL_FIRST) begin
                            win_valid_q <= 1'b1;
                            win_x_q     <= col_q - COL_FIRST;
                            win_y_q     <= row_q - ROW_FIRST;
                        end
                        if (col_last && row_last) begin
                            state_q      <= ST_FILL;
                            frame_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_FILL;
                endcase
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign win        = win_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x5 image with a 3x3 window.
module tb_conv_window_gen;

    typedef logic [2:0][2:0][7:0] win_t;
    typedef struct {
        win_t       w;
        logic [2:0] x;
        logic [2:0] y;
        logic       fd;
    } exp_t;

    logic       clock;
    logic       nreset;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       win_valid;
    win_t       win;
    logic [2:0] win_x;
    logic [2:0] win_y;
    logic       frame_done;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   win_seen = 0;
    int   tcol = 0;
    int   trow = 0;
    logic acc_prev = 1'b0;

    conv_window_gen #(
        .SIZE      (3),
        .WIDTH_BIT (8),
        .IMG_W     (5),
        .IMG_H     (5)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win        (win),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    function automatic win_t win3(input int a0, input int a1, input int a2,
                                  input int a3, input int a4, input int a5,
                                  input int a6, input int a7, input int a8);
        win_t w;
        w[0][0] = 8'(a0); w[0][1] = 8'(a1); w[0][2] = 8'(a2);
        w[1][0] = 8'(a3); w[1][1] = 8'(a4); w[1][2] = 8'(a5);
        w[2][0] = 8'(a6); w[2][1] = 8'(a7); w[2][2] = 8'(a8);
        return w;
    endfunction

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: what the DUT accepted at the last rising edge decides whether a window may appear.
    always @(posedge clock) acc_prev = pix_valid && nreset;

    always @(negedge clock) begin
        exp_t e;
        if (win_valid === 1'b1) begin
            win_seen++;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_window: got win %h at (%0d,%0d), want none", win, win_x, win_y);
            end else begin
                e = q.pop_front();
                if (win !== e.w || win_x !== e.x || win_y !== e.y || frame_done !== e.fd) begin
                    n_err++;
                    $display("FAIL window: got %h (%0d,%0d) fd=%b want %h (%0d,%0d) fd=%b",
                             win, win_x, win_y, frame_done, e.w, e.x, e.y, e.fd);
                end
            end
        end else if (frame_done !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_done_alone: got %b want 0", frame_done);
        end
        if (!acc_prev) begin
            n_vec++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_cycle: got valid=%b fd=%b want 0/0", win_valid, frame_done);
            end
        end
    end

    task automatic send(input int d);
        exp_t e;
        pix_valid = 1'b1;
        pix_data  = 8'(d);
        if (trow >= 2 && tcol >= 2) begin
            e.w  = win3(d-12, d-11, d-10, d-7, d-6, d-5, d-2, d-1, d);
            e.x  = 3'(tcol - 2);
            e.y  = 3'(trow - 2);
            e.fd = (tcol == 4 && trow == 4);
            q.push_back(e);
        end
        if (tcol == 4) begin
            tcol = 0;
            trow = (trow == 4) ? 0 : trow + 1;
        end else begin
            tcol++;
        end
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame(input int base, input bit gaps, input bit chk);
        for (int i = 0; i < 25; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 9) < 4) idle(1);
            end
            send(base + i);
            if (chk) begin
                case (i)
                    12: begin
                        check("first_win", 72'(win),
                              72'(win3(base, base+1, base+2, base+5, base+6, base+7,
                                       base+10, base+11, base+12)));
                        check("first_valid_xy", 72'({win_valid, win_x, win_y}), 72'({1'b1, 3'd0, 3'd0}));
                    end
                    15, 16, 20, 21:
                        check("row_wrap_no_valid", 72'(win_valid), 72'(1'b0));
                    17:
                        check("after_wrap_win", 72'(win),
                              72'(win3(base+5, base+6, base+7, base+10, base+11, base+12,
                                       base+15, base+16, base+17)));
                    24: begin
                        check("last_win", 72'(win),
                              72'(win3(base+12, base+13, base+14, base+17, base+18, base+19,
                                       base+22, base+23, base+24)));
                        check("last_xy_fd", 72'({win_valid, frame_done, win_x, win_y}),
                              72'({1'b1, 1'b1, 3'd2, 3'd2}));
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_valid"}, 72'(win_valid), 72'(1'b0));
        check({nm, "_fd"},    72'(frame_done), 72'(1'b0));
        check({nm, "_win"},   72'(win), 72'(0));
        check({nm, "_x"},     72'(win_x), 72'(0));
        check({nm, "_y"},     72'(win_y), 72'(0));
    endtask

    initial begin
        int s;
        nreset    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_zero("reset");
        nreset = 1'b1;

        // Basic frame followed immediately by a second frame.
        s = win_seen;
        frame(0, 1'b0, 1'b1);
        frame(100, 1'b0, 1'b1);
        idle(2);
        check("b2b_window_count", 72'(win_seen - s), 72'(18));

        // Same frame with random input gaps.
        s = win_seen;
        frame(0, 1'b1, 1'b1);
        idle(2);
        check("gap_window_count", 72'(win_seen - s), 72'(9));

        // Reset after 14 pixels.
        s = win_seen;
        for (int i = 0; i < 14; i++) send(i);
        nreset = 1'b0;
        @(posedge clock);
        #1;
        nreset = 1'b1;
        tcol = 0;
        trow = 0;
        check_zero("mid_reset");
        check("partial_window_count", 72'(win_seen - s), 72'(2));
        check("partial_queue_drained", 72'(q.size()), 72'(0));
        q.delete();
        s = win_seen;
        frame(200, 1'b0, 1'b1);
        idle(2);
        check("post_reset_window_count", 72'(win_seen - s), 72'(9));

        // Reset coincident with a valid pixel.
        for (int i = 0; i < 7; i++) send(i);
        nreset    = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'd99;
        @(posedge clock);
        #1;
        nreset    = 1'b1;
        pix_valid = 1'b0;
        tcol = 0;
        trow = 0;
        check("coincident_counters", 72'({dut.col_q, dut.row_q}), 72'(0));
        check("coincident_valid", 72'(win_valid), 72'(1'b0));
        s = win_seen;
        frame(150, 1'b0, 1'b1);
        idle(2);
        check("coincident_window_count", 72'(win_seen - s), 72'(9));

        check("queue_empty", 72'(q.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
